// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU response checker.
//   stateT           : checker run state (IDLE / RUN / DONE)
//   DEF_WIDTH        : default ALU data width
//   DEF_CNT_W        : default counter / index width
//   DEF_NUM_VECTORS  : default number of vectors per run
package alu_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   localparam int unsigned DEF_WIDTH       = 8;
   localparam int unsigned DEF_CNT_W       = 8;
   localparam int unsigned DEF_NUM_VECTORS = 21;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears q
//   clr   : synchronous clear, clears q
//   inc   : increment request; ignored once q is all-ones
//   q     : count value
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_checker.sv
// Response checker for the 8-bit ALU self-test path. Accepts one
// (y, zero, exp_y, exp_zero) tuple per valid/ready handshake, counts
// vectors and mismatches, captures the first failing tuple and reports
// pass/fail once NUM_VECTORS tuples have been consumed.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a run (ignored while running)
//   in_valid / in_ready   : tuple handshake; in_ready high only in RUN
//   y, zero               : ALU result and zero flag
//   exp_y, exp_zero       : expected result and zero flag
//   done, pass            : run complete, and no mismatches seen
//   vec_count, err_count  : tuples accepted, mismatches (saturating)
//   first_err_idx/_y/_exp : index, y and exp_y of the first mismatch
//   bad_vector            : sticky, an accepted tuple had exp_zero
//                           inconsistent with exp_y
module alu_checker
   import alu_chk_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned NUM_VECTORS = DEF_NUM_VECTORS,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] y,
   input  logic             zero,
   input  logic [WIDTH-1:0] exp_y,
   input  logic             exp_zero,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_y,
   output logic [WIDTH-1:0] first_err_exp,
   output logic             bad_vector
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   stateT state;
   stateT stateNext;

   logic runStart;
   logic fire;
   logic mismatch;
   logic badTuple;
   logic lastFire;

   assign in_ready = (state == RUN);
   assign runStart = start && (state != RUN);
   assign fire     = in_valid && in_ready;
   assign mismatch = (y != exp_y) || (zero != exp_zero);
   assign badTuple = (exp_zero != (exp_y == '0));
   // vec_count still holds the pre-increment value, so the final tuple
   // is the one that arrives while it equals NUM_VECTORS-1.
   assign lastFire = fire && (vec_count == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (start)    stateNext = RUN;
         RUN:     if (lastFire) stateNext = DONE;
         DONE:    if (start)    stateNext = RUN;
         default:               stateNext = IDLE;
      endcase
   end

   sat_counter #(.CNT_W(CNT_W)) uVecCnt (
      .clk   (clk),
      .reset (reset),
      .clr   (runStart),
      .inc   (fire),
      .q     (vec_count)
   );

   sat_counter #(.CNT_W(CNT_W)) uErrCnt (
      .clk   (clk),
      .reset (reset),
      .clr   (runStart),
      .inc   (fire && mismatch),
      .q     (err_count)
   );

   // err_count never returns to zero within a run, so a zero count
   // identifies the first mismatch without a separate flag.
   always_ff @(posedge clk) begin
      if (reset || runStart) begin
         first_err_idx <= '0;
         first_err_y   <= '0;
         first_err_exp <= '0;
      end else if (fire && mismatch && (err_count == '0)) begin
         first_err_idx <= vec_count;
         first_err_y   <= y;
         first_err_exp <= exp_y;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || runStart) begin
         bad_vector <= 1'b0;
      end else if (fire && badTuple) begin
         bad_vector <= 1'b1;
      end
   end

   assign done = (state == DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: doc/alu_checker.md
# alu_checker

Self-checking response monitor for the 8-bit ALU: the receiving end of the test-vector stream that drives the ALU. It accepts one (y, zero, expected y, expected zero) tuple per handshake, compares actual against expected, counts vectors and mismatches, captures the first failure, and reports pass/fail once the programmed number of vectors has been consumed. It sits beside the ALU in the hardware self-test path. The vector source drives `a`/`b`/`f` into the ALU and presents the ALU outputs plus the expected values here.

## Interface
Parameters:
- `WIDTH`, 8, ALU data width.
- `NUM_VECTORS`, 21, vectors per run; must be 1..2^CNT_W-1.
- `CNT_W`, 8, width of all counters and indices.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begins a run; ignored while RUN.
- `in_valid`  in  1  source has a tuple.
- `in_ready`  out  1  checker accepts a tuple; equals 1 exactly in RUN.
- `y`  in  WIDTH  ALU result.
- `zero`  in  1  ALU zero flag.
- `exp_y`  in  WIDTH  expected result.
- `exp_zero`  in  1  expected zero flag.
- `done`  out  1  run complete; level, held in DONE.
- `pass`  out  1  valid when `done`: 1 iff `err_count`==0.
- `vec_count`  out  CNT_W  tuples accepted this run.
- `err_count`  out  CNT_W  mismatches this run; saturates at all-ones.
- `first_err_idx`  out  CNT_W  index (0-based) of first mismatching tuple.
- `first_err_y`  out  WIDTH  `y` of first mismatch.
- `first_err_exp`  out  WIDTH  `exp_y` of first mismatch.
- `bad_vector`  out  1  sticky: some accepted tuple had `exp_zero` != (`exp_y`==0).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start` -> RUN; clear all counters, capture regs, `bad_vector`, `pass`.
- RUN: handshake fires when `in_valid` && `in_ready`. On fire, `vec_count` += 1.
  - Mismatch = (`y` != `exp_y`) || (`zero` != `exp_zero`). On mismatch, `err_count` += 1 (saturating).
  - On the first mismatch of the run, also load `first_err_idx` = current `vec_count`, `first_err_y`, `first_err_exp`.
  - When a fire brings `vec_count` to NUM_VECTORS -> DONE.
- DONE: `done`=1 and `pass` = (`err_count`==0). Both hold until `start`, which clears everything and re-enters RUN directly. `reset` -> IDLE.
- `start` asserted during RUN has no effect. `start` coinciding with a fire in IDLE or DONE: the tuple is not accepted (`in_ready`=0).
- `bad_vector` is set alongside normal compare. It does not by itself count as an error.
- A mismatch on `zero` only, with `y` equal, counts as an error. `first_err_y` and `first_err_exp` then hold equal values.
- Reset values: state IDLE; `in_ready`, `done`, `pass`, `bad_vector` = 0; all counters and capture regs = 0.
- Reset in mid-run aborts immediately; partial counts are discarded.

## Timing
- `in_ready` decodes combinationally from the state register only, never from `in_valid`.
- All other outputs are registered and update on the edge that samples the fire.
- The DONE transition happens on the same edge as the last fire, so `done` rises the cycle after the final handshake. Total run length is NUM_VECTORS handshake cycles plus 1 with `in_valid` held high.
- `in_valid` gaps are allowed. The checker waits indefinitely; there is no timeout.
- `err_count` saturation: at all-ones, a further mismatch leaves it unchanged and `pass` stays 0.

## Structure
- Package `alu_chk_pkg`: state enum (IDLE/RUN/DONE) and the default `WIDTH`/`CNT_W`/`NUM_VECTORS` constants.
- Sub-module `sat_counter` (`CNT_W`, `clk`/`reset`/`clr`/`inc` -> `q`, saturating) is instantiated twice, for `vec_count` and `err_count`.
- Compare logic and first-error capture are inline.

## Test plan
- All match: `start`, then 21 tuples with y==exp_y and zero==exp_zero, in_valid always 1. Expect `done`=1 one cycle after the 21st fire, `pass`=1, `err_count`=0, `vec_count`=21.
- Single mismatch: tuple 5 has y=8'h3C, exp_y=8'h3D. Expect `err_count`=1, `first_err_idx`=5, `first_err_y`=8'h3C, `first_err_exp`=8'h3D, `pass`=0.
- Zero-flag only: tuple 0 has y=exp_y=8'h00, zero=0, exp_zero=1. Expect `err_count`=1 and `first_err_idx`=0. Separately, exp_y=8'h01 with exp_zero=1 sets `bad_vector`=1.
- Backpressure and gaps: toggle `in_valid` randomly and assert `start` mid-run. Expect `in_ready`=1 throughout RUN, `start` ignored, and `vec_count` incrementing only on fires.
- Restart from DONE: after a failing run, pulse `start`. Expect all counters, `pass`, `bad_vector` and capture regs at 0 and `in_ready`=1 the next cycle.
- Reset at vector 10: assert `reset` one cycle. Expect state IDLE, all outputs at 0, `in_ready`=0, and no fire accepted until `start`.
- Saturation: with CNT_W=4 and NUM_VECTORS=15, drive all-mismatch tuples. Expect `err_count`=15 and `pass`=0.
